// File: rtl/hard_pkg.sv
// Shared sizing defaults and signed word types for the hard FIR filter.
package hard_pkg;

  localparam int NTAPS_DEF = 64;
  localparam int DW_DEF    = 32;
  localparam int FRAC_DEF  = 11;

  // Headroom so that NTAPS full-precision products can never overflow the sum.
  function automatic int acc_width(input int dw, input int ntaps);
    return 2 * dw + $clog2(ntaps) + 1;
  endfunction

  localparam int ACC_W_DEF = acc_width(DW_DEF, NTAPS_DEF);

  typedef logic signed [DW_DEF-1:0]    sample_t;
  typedef logic signed [DW_DEF-1:0]    coeff_t;
  typedef logic signed [2*DW_DEF-1:0]  prod_t;
  typedef logic signed [ACC_W_DEF-1:0] acc_t;

endpackage

// File: rtl/hard_dot.sv
// Combinational dot product of coefficient and sample lines with round-half-up
// rescaling from Q.FRAC back to integer.
module hard_dot
  import hard_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [DW-1:0] c      [NTAPS],
  input  logic signed [DW-1:0] d      [NTAPS],
  output logic signed [DW-1:0] result
);

  localparam int ACC_W = acc_width(DW, NTAPS);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

  logic signed [2*DW-1:0]  prod [NTAPS];
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rounded;

  // NOTE: blocking assignments here model pure combinational logic; every
  // variable gets a value on every pass, so no latch is inferred.
  always_comb begin
    acc = '0;
    for (int i = 0; i < NTAPS; i++) begin
      prod[i] = (2*DW)'(c[i]) * (2*DW)'(d[i]);
      acc    += ACC_W'(prod[i]);
    end
    rounded = acc + HALF;
    // Arithmetic shift floors toward -inf, so adding half first rounds half up.
    result  = DW'(rounded >>> FRAC);
  end

endmodule

// File: rtl/hard.sv
// NTAPS-tap FIR: shifting coefficient and sample lines feeding a registered
// dot product.
module hard
  import hard_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEF,
  parameter int DW    = DW_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coeff_we,
  input  logic                 sample_we,
  input  logic signed [DW-1:0] in,
  output logic signed [DW-1:0] out
);

  logic signed [DW-1:0] c [NTAPS];
  logic signed [DW-1:0] d [NTAPS];
  logic signed [DW-1:0] dot_result;

  hard_dot #(
    .NTAPS(NTAPS),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_dot (
    .c     (c),
    .d     (d),
    .result(dot_result)
  );

  // NOTE: non-blocking assignments let every slot read its neighbour's old
  // value, giving a true one-place shift per edge. These lines are reset
  // because the filter output must read exactly zero for unwritten taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        c[i] <= '0;
        d[i] <= '0;
      end
      out <= '0;
    end else begin
      if (coeff_we) begin
        for (int i = 0; i < NTAPS - 1; i++) c[i] <= c[i+1];
        c[NTAPS-1] <= in;
      end
      if (sample_we) begin
        for (int i = 0; i < NTAPS - 1; i++) d[i] <= d[i+1];
        d[NTAPS-1] <= in;
      end
      out <= dot_result;
    end
  end

endmodule

// File: tb/tb_hard.sv
// Scoreboard bench for hard: expectations are queued as stimulus is loaded and
// popped when the registered output is sampled on the falling edge.
module tb_hard;
  import hard_pkg::*;

  localparam int NT = 64;

  logic               clk       = 1'b0;
  logic               reset     = 1'b0;
  logic               coeff_we  = 1'b0;
  logic               sample_we = 1'b0;
  logic signed [31:0] din       = '0;
  logic signed [31:0] dout;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  exp_q  [$];
  real exp_rq [$];
  int  cbuf [NT];
  int  sbuf [NT];

  always #5 clk = ~clk;

  hard #(.NTAPS(NT), .DW(32), .FRAC(11)) dut (
    .clk      (clk),
    .reset    (reset),
    .coeff_we (coeff_we),
    .sample_we(sample_we),
    .in       (din),
    .out      (dout)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic write_coeff(input int v);
    din = v; coeff_we = 1'b1;
    @(negedge clk);
    coeff_we = 1'b0;
  endtask

  task automatic write_sample(input int v);
    din = v; sample_we = 1'b1;
    @(negedge clk);
    sample_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < NT; i++) write_coeff(cbuf[i]);
    for (int i = 0; i < NT; i++) write_sample(sbuf[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance one clock and return the registered output.
  task automatic next_out(output logic signed [31:0] v);
    @(negedge clk);
    v = dout;
  endtask

  task automatic test_reset();
    logic signed [31:0] got;
    int exp;
    reset = 1'b1; din = 2048; coeff_we = 1'b1; sample_we = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; coeff_we = 1'b0; sample_we = 1'b0;
    exp_q.push_back(0);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL reset_out: out=%0d expected=%0d", got, exp);
    end
    // One joint write; any write leaked through reset would multiply this.
    din = 2048; coeff_we = 1'b1; sample_we = 1'b1;
    @(negedge clk);
    coeff_we = 1'b0; sample_we = 1'b0;
    exp_q.push_back(2048);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL joint_write: out=%0d expected=%0d", got, exp);
    end
  endtask

  task automatic test_unity_hold();
    logic signed [31:0] got;
    int exp;
    do_reset();
    for (int i = 0; i < NT; i++) begin cbuf[i] = 2048; sbuf[i] = i + 1; end
    load_all();
    exp_q.push_back(2080);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL unity: out=%0d expected=%0d", got, exp);
    end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(2080);
      next_out(got); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL hold_%0d: out=%0d expected=%0d", k, got, exp);
      end
    end
  endtask

  task automatic test_partial();
    logic signed [31:0] got;
    int exp;
    do_reset();
    write_coeff(2048);
    write_sample(9);
    exp_q.push_back(9);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL partial_1: out=%0d expected=%0d", got, exp);
    end
    write_sample(4);
    exp_q.push_back(4);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL partial_2: out=%0d expected=%0d", got, exp);
    end
  endtask

  task automatic test_sliding();
    logic signed [31:0] got;
    int exp;
    do_reset();
    for (int i = 0; i < NT; i++) begin
      cbuf[i] = (i == 0) ? 2048 : 0;
      sbuf[i] = 3 * i + 11;
    end
    sbuf[0] = 100; sbuf[1] = 5;
    load_all();
    exp_q.push_back(100);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL align: out=%0d expected=%0d", got, exp);
    end
    write_sample(7);
    exp_q.push_back(5);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL slide: out=%0d expected=%0d", got, exp);
    end
  endtask

  task automatic test_negative_round();
    logic signed [31:0] got;
    int exp;
    do_reset();
    for (int i = 0; i < NT; i++) begin cbuf[i] = -1024; sbuf[i] = 3; end
    load_all();
    exp_q.push_back(-96);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL negative: out=%0d expected=%0d", got, exp);
    end
    // +0.5 and -0.5 both round up: to 1 and to 0.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < NT; i++) begin cbuf[i] = 0; sbuf[i] = 0; end
      cbuf[10] = (k == 0) ? 1 : -1;
      sbuf[10] = 1024;
      load_all();
      exp_q.push_back((k == 0) ? 1 : 0);
      next_out(got); exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fails++; $display("FAIL half_round_%0d: out=%0d expected=%0d", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic signed [31:0] got;
    int exp;
    do_reset();
    for (int i = 0; i < 30; i++) write_coeff(1000 + i);
    do_reset();
    for (int i = 0; i < NT; i++) begin cbuf[i] = 2048; sbuf[i] = i + 1; end
    load_all();
    exp_q.push_back(2080);
    next_out(got); exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fails++; $display("FAIL midload: out=%0d expected=%0d", got, exp);
    end
  endtask

  task automatic test_random();
    logic signed [31:0] got;
    real cr, sum, expr, diff;
    for (int t = 0; t < 100; t++) begin
      do_reset();
      sum = 0.0;
      for (int i = 0; i < NT; i++) begin
        cr      = (real'($urandom_range(7998, 0)) - 3999.0) / 2000.0;
        cbuf[i] = $rtoi(cr * 2048.0 + ((cr >= 0.0) ? 0.5 : -0.5));
        sbuf[i] = int'($urandom_range(508, 0)) - 254;
        sum    += real'(sbuf[i]) * cr;
      end
      load_all();
      exp_rq.push_back(sum);
      next_out(got); expr = exp_rq.pop_front();
      diff = real'(got) - expr;
      n_checks++;
      if ($isunknown(got) || diff > 2.0 || diff < -2.0) begin
        n_fails++;
        $display("FAIL random_%0d: out=%0d expected=%f (+/-2)", t, got, expr);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unity_hold();
    test_partial();
    test_sliding();
    test_negative_round();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hard.md
HARD -- requirements
Module: hard

Interface
REQ-001 Parameter NTAPS, default 64, number of taps.
REQ-002 Parameter DW, default 32, width of in/out words.
REQ-003 Parameter FRAC, default 11, coefficient fractional bits (Q.11).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 coeff_we  input  1  when high at a clock edge, in is loaded as a coefficient.
REQ-007 sample_we  input  1  when high at a clock edge, in is loaded as a sample.
REQ-008 in  input  DW  signed two's-complement coefficient (Q.FRAC) or integer sample.
REQ-009 out  output  DW  signed integer filter result, registered.

Function
REQ-010 Coefficient store c[0..NTAPS-1] shall shift on each coeff_we: c[NTAPS-1]<=in, c[i]<=c[i+1]; after exactly NTAPS writes c[0] holds the first value written.
REQ-011 Sample delay line d[0..NTAPS-1] shall shift on each sample_we identically: d[NTAPS-1]<=in, d[i]<=d[i+1]; d[0] holds the oldest of the last NTAPS samples.
REQ-012 Fewer than NTAPS writes leave reset zeros in the low-index slots; writes beyond NTAPS discard the oldest entry (sliding window, no wrap error).
REQ-013 coeff_we and sample_we asserted together shall both take effect on the same edge from the same in value.
REQ-014 Products shall be full-precision signed 2*DW bits; accumulation shall use a signed accumulator of 2*DW+log2(NTAPS)+1 bits (71 for defaults) with no overflow.
REQ-015 Result = (sum over i of d[i]*c[i] + 2^(FRAC-1)) arithmetically shifted right by FRAC, i.e. round-half-up, then truncated to the low DW bits.
REQ-016 out shall be registered every clock from the current c/d contents: latency one clock after the edge that writes the last sample or coefficient.
REQ-017 With neither strobe active, c, d and out shall hold steady (out recomputes to the same value).
REQ-018 No handshake or busy signal; a write is accepted every cycle.

Reset
REQ-019 reset high at a clock edge shall clear all c[i], all d[i] and out to 0; reset takes priority over coeff_we/sample_we.
REQ-020 reset asserted mid-load shall discard the partial load; the next write counts as write number one.

Structure
REQ-021 Package hard_pkg shall hold NTAPS/DW/FRAC defaults, the derived accumulator width constant and the signed sample/coefficient/accumulator typedefs.
REQ-022 One sub-module, hard_dot, shall compute the combinational dot product plus rounding shift (multipliers + adder tree); hard holds the shift registers and out register.

Verification
REQ-023 Reset: after reset with no writes -> out = 0 next cycle; writes during reset ignored.
REQ-024 Unity gain: 64 coefficients 2048 (1.0), samples 1..64 -> out = 2080.
REQ-025 Alignment/sliding: c[0]=2048, others 0, samples 100,5,...(64 total) -> out = 100; 65th sample 7 -> out = 5.
REQ-026 Negative and rounding: all coeffs -1024 (-0.5), all samples 3 -> out = -96; single coeff 1 with matching sample 1024, all else 0 -> out = 1 (0.5 rounds up).
REQ-027 Random: 100 trials, reset each, 64 coeffs round(c*2048) with c in (-2,2), 64 samples in (-255,255) -> out within +/-2 of the real-valued sum of sample*c.
REQ-028 Reset mid-load: 30 coefficients written, reset, then full 64-entry unity load with samples 1..64 -> out = 2080.
